// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - RV32I ID stage: decode, hazard detect/forward select, ID/EX register.
module decode_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            flush,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  output logic            out_valid,
  output logic [11:0]     operation,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] imm,
  output logic [1:0]      need_forward,
  output logic [4:0]      rd_addr,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            illegal
);

  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_I      = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [11:0] OP_BUBBLE = 12'b000000010011;

  logic [6:0] opc;
  logic [2:0] funct3;
  logic [4:0] rd_f, rs1_f, rs2_f;
  logic       is_r, is_i, is_ld, is_st, is_br, legal, uses_rs2, is_shift;
  logic       prev_live, match1, match2, stall, accept;

  logic            valid_q, valid_d;
  logic [11:0]     op_q, op_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
  logic [1:0]      nf_q, nf_d;
  logic [4:0]      rd_q, rd_d;
  logic            rw_q, rw_d, mr_q, mr_d, mw_q, mw_d, br_q, br_d, ill_q, ill_d;

  assign opc      = instr[6:0];
  assign funct3   = instr[14:12];
  assign rd_f     = instr[11:7];
  assign rs1_f    = instr[19:15];
  assign rs2_f    = instr[24:20];
  assign is_r     = (opc == OP_R);
  assign is_i     = (opc == OP_I);
  assign is_ld    = (opc == OP_LOAD);
  assign is_st    = (opc == OP_STORE);
  assign is_br    = (opc == OP_BRANCH);
  assign legal    = is_r | is_i | is_ld | is_st | is_br;
  assign uses_rs2 = is_r | is_st | is_br;
  assign is_shift = is_i & ((funct3 == 3'b001) | (funct3 == 3'b101));

  assign rf_rs1_addr = rs1_f;
  assign rf_rs2_addr = rs2_f;

  // Only the slot issued last cycle is checked; older producers are already in the register file.
  assign prev_live = valid_q & rw_q & (rd_q != 5'd0);
  assign match1    = legal & prev_live & (rs1_f == rd_q);
  assign match2    = uses_rs2 & prev_live & (rs2_f == rd_q);
  assign stall     = in_valid & ~flush & ((mr_q & (match1 | match2)) | (is_st & match2));
  assign in_ready  = ~stall;
  assign accept    = in_valid & in_ready & ~flush;

  always_comb begin
    valid_d = 1'b0;
    op_d    = OP_BUBBLE;
    rs1_d   = '0;
    rs2_d   = '0;
    imm_d   = '0;
    nf_d    = 2'b00;
    rd_d    = 5'd0;
    rw_d    = 1'b0;
    mr_d    = 1'b0;
    mw_d    = 1'b0;
    br_d    = 1'b0;
    ill_d   = 1'b0;
    if (accept && !legal) begin
      ill_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b1;
      op_d    = {2'b00, funct3, opc};
      if (is_r)
        op_d[11] = instr[30];
      if (is_i && funct3 == 3'b101)
        op_d[10] = instr[30];
      rs1_d = rf_rs1_data;
      rs2_d = rf_rs2_data;
      // Shift immediates carry only shamt; instr[30] already travels in operation[10].
      if (is_shift)
        imm_d = {{(XLEN-5){1'b0}}, instr[24:20]};
      else if (is_i || is_ld)
        imm_d = {{(XLEN-12){instr[31]}}, instr[31:20]};
      else if (is_st)
        imm_d = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      else if (is_br)
        imm_d = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      nf_d = {match1, match2 & (is_r | is_br)};
      if (is_r || is_i || is_ld) begin
        rd_d = rd_f;
        rw_d = (rd_f != 5'd0);
      end
      mr_d = is_ld;
      mw_d = is_st;
      br_d = is_br;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      op_q    <= OP_BUBBLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      nf_q    <= 2'b00;
      rd_q    <= 5'd0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      br_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      nf_q    <= nf_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      br_q    <= br_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid    = valid_q;
  assign operation    = op_q;
  assign rs1          = rs1_q;
  assign rs2          = rs2_q;
  assign imm          = imm_q;
  assign need_forward = nf_q;
  assign rd_addr      = rd_q;
  assign reg_write    = rw_q;
  assign mem_read     = mr_q;
  assign mem_write    = mw_q;
  assign branch       = br_q;
  assign illegal      = ill_q;

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - directed and randomized checks of decode_issue against a reference model.
module tb_decode_issue;

  typedef struct packed {
    logic        v;
    logic [11:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] im;
    logic [1:0]  nf;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, ill;
  } slot_t;

  localparam slot_t BUBBLE = '{v: 1'b0, op: 12'b000000010011, a: 32'd0, b: 32'd0, im: 32'd0,
                               nf: 2'b00, rd: 5'd0, rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0, ill: 1'b0};

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush;
  logic [31:0] instr, rf_rs1_data, rf_rs2_data, rs1, rs2, imm;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr, rd_addr;
  logic        out_valid, reg_write, mem_read, mem_write, branch, illegal;
  logic [11:0] operation;
  logic [1:0]  need_forward;

  int    checks = 0;
  int    errors = 0;
  slot_t ref_q;
  logic  ref_rdy;
  logic  rdy_seen;

  always #5 clk = ~clk;

  decode_issue #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .out_valid(out_valid),
    .operation(operation), .rs1(rs1), .rs2(rs2), .imm(imm), .need_forward(need_forward),
    .rd_addr(rd_addr), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .illegal(illegal)
  );

  function automatic slot_t actual();
    slot_t s;
    s.v = out_valid; s.op = operation; s.a = rs1; s.b = rs2; s.im = imm; s.nf = need_forward;
    s.rd = rd_addr; s.rw = reg_write; s.mr = mem_read; s.mw = mem_write; s.br = branch; s.ill = illegal;
    return s;
  endfunction

  // Reference: what the next ID/EX slot should be, from the instruction-set rules and the last slot.
  function automatic void model(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2,
                                input logic v, input logic f, input slot_t p,
                                output slot_t n, output logic rdy);
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    bit r = (opc == 7'b0110011), i = (opc == 7'b0010011), l = (opc == 7'b0000011);
    bit s = (opc == 7'b0100011), b = (opc == 7'b1100011);
    bit legal = r || i || l || s || b;
    bit live = p.v && p.rw && p.rd != 0;
    bit m1 = legal && live && ins[19:15] == p.rd;
    bit m2 = (r || s || b) && live && ins[24:20] == p.rd;
    bit stall = v && !f && ((p.mr && (m1 || m2)) || (s && m2));
    logic [11:0] i12;
    logic [12:0] b13;
    rdy = !stall;
    n = BUBBLE;
    if (v && !f && !stall) begin
      if (!legal) n.ill = 1'b1;
      else begin
        n.v = 1'b1;
        n.op = {(r ? ins[30] : 1'b0), ((i && f3 == 3'd5) ? ins[30] : 1'b0), f3, opc};
        n.a = d1;
        n.b = d2;
        if (i && (f3 == 3'd1 || f3 == 3'd5)) n.im = 32'(ins[24:20]);
        else if (i || l) begin i12 = ins[31:20]; n.im = 32'($signed(i12)); end
        else if (s) begin i12 = {ins[31:25], ins[11:7]}; n.im = 32'($signed(i12)); end
        else if (b) begin b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; n.im = 32'($signed(b13)); end
        n.nf = {m1, m2 && (r || b)};
        if (r || i || l) begin n.rd = ins[11:7]; n.rw = (ins[11:7] != 0); end
        n.mr = l; n.mw = s; n.br = b;
      end
    end
  endfunction

  task automatic cycle(input logic [31:0] ins, input logic v, input logic f);
    slot_t n;
    @(negedge clk);
    instr = ins; in_valid = v; flush = f;
    rf_rs1_data = $urandom; rf_rs2_data = $urandom;
    #1;
    rdy_seen = in_ready;
    model(ins, rf_rs1_data, rf_rs2_data, v, f, ref_q, n, ref_rdy);
    @(posedge clk);
    #1;
    ref_q = n;
  endtask

  function automatic logic [31:0] enc_r(input logic b30, input int rs2f, input int rs1f, input int f3, input int rd);
    return {1'b0, b30, 5'd0, 5'(rs2f), 5'(rs1f), 3'(f3), 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [11:0] im, input int rs1f, input int f3, input int rd);
    return {im, 5'(rs1f), 3'(f3), 5'(rd), opc};
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; instr = 32'd0;
    rf_rs1_data = 32'd0; rf_rs2_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (actual() !== BUBBLE || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got %h ready %b, want %h ready 1", actual(), in_ready, BUBBLE);
    end
    @(negedge clk); reset = 1'b0;
    ref_q = BUBBLE;
  endtask

  task automatic test_forward_sub();
    cycle(enc_r(1'b0, 2, 1, 0, 3), 1'b1, 1'b0);
    cycle(enc_r(1'b1, 5, 3, 0, 4), 1'b1, 1'b0);
    checks++;
    if (operation !== 12'b100000110011 || need_forward !== 2'b10 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL fwd_sub: op %b nf %b v %b, want op 100000110011 nf 10 v 1", operation, need_forward, out_valid);
    end
    checks++;
    if (actual() !== ref_q) begin
      errors++;
      $display("FAIL fwd_sub_slot: got %h want %h", actual(), ref_q);
    end
  endtask

  task automatic test_load_use();
    cycle(enc_i(7'b0000011, 12'd0, 1, 2, 5), 1'b1, 1'b0);
    cycle(enc_r(1'b0, 5, 5, 0, 6), 1'b1, 1'b0);
    checks++;
    if (rdy_seen !== 1'b0 || out_valid !== 1'b0 || operation !== 12'b000000010011) begin
      errors++;
      $display("FAIL load_use_stall: ready %b v %b op %b, want ready 0 v 0 op 000000010011", rdy_seen, out_valid, operation);
    end
    cycle(enc_r(1'b0, 5, 5, 0, 6), 1'b1, 1'b0);
    checks++;
    if (rdy_seen !== 1'b1 || out_valid !== 1'b1 || need_forward !== 2'b00 || rd_addr !== 5'd6) begin
      errors++;
      $display("FAIL load_use_retry: ready %b v %b nf %b rd %0d, want ready 1 v 1 nf 00 rd 6", rdy_seen, out_valid, need_forward, rd_addr);
    end
  endtask

  task automatic test_stall_flush();
    cycle(enc_i(7'b0000011, 12'd0, 1, 2, 5), 1'b1, 1'b0);
    cycle(enc_r(1'b0, 5, 5, 0, 6), 1'b1, 1'b1);
    checks++;
    if (actual() !== BUBBLE) begin
      errors++;
      $display("FAIL stall_flush_bubble: got %h want %h", actual(), BUBBLE);
    end
    cycle(enc_r(1'b0, 5, 5, 0, 6), 1'b0, 1'b0);
    checks++;
    if (rdy_seen !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_flush_after: ready %b v %b, want ready 1 v 0", rdy_seen, out_valid);
    end
  endtask

  task automatic test_srai_x0();
    cycle(enc_i(7'b0010011, 12'h403, 7, 5, 7), 1'b1, 1'b0);
    checks++;
    if (operation !== 12'b011010010011 || imm !== 32'd3) begin
      errors++;
      $display("FAIL srai: op %b imm %h, want op 011010010011 imm 00000003", operation, imm);
    end
    cycle(enc_i(7'b0010011, 12'd1, 1, 0, 0), 1'b1, 1'b0);
    checks++;
    if (reg_write !== 1'b0 || imm !== 32'd1) begin
      errors++;
      $display("FAIL addi_x0: rw %b imm %h, want rw 0 imm 00000001", reg_write, imm);
    end
    cycle(enc_r(1'b0, 0, 0, 0, 2), 1'b1, 1'b0);
    checks++;
    if (need_forward !== 2'b00 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL x0_no_fwd: nf %b v %b, want nf 00 v 1", need_forward, out_valid);
    end
  endtask

  task automatic test_branch_illegal();
    cycle(32'hFE208EE3, 1'b1, 1'b0);
    checks++;
    if (operation !== 12'b000001100011 || imm !== 32'hFFFFFFFC || branch !== 1'b1 || rd_addr !== 5'd0 || reg_write !== 1'b0) begin
      errors++;
      $display("FAIL beq: op %b imm %h br %b rd %0d rw %b, want op 000001100011 imm fffffffc br 1 rd 0 rw 0",
               operation, imm, branch, rd_addr, reg_write);
    end
    cycle(32'h000012B7, 1'b1, 1'b0);
    checks++;
    if (illegal !== 1'b1 || out_valid !== 1'b0 || operation !== 12'b000000010011) begin
      errors++;
      $display("FAIL illegal_pulse: ill %b v %b op %b, want ill 1 v 0 op 000000010011", illegal, out_valid, operation);
    end
    cycle(32'd0, 1'b0, 1'b0);
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_one_cycle: ill %b, want 0", illegal);
    end
  endtask

  task automatic test_async_reset();
    cycle(enc_i(7'b0000011, 12'd4, 1, 2, 5), 1'b1, 1'b0);
    @(negedge clk);
    instr = enc_r(1'b0, 5, 5, 0, 6); in_valid = 1'b1; flush = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_pre_stall: ready %b, want 0", in_ready);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (actual() !== BUBBLE || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got %h ready %b, want %h ready 1", actual(), in_ready, BUBBLE);
    end
    #1 reset = 1'b0;
    ref_q = BUBBLE;
    cycle(enc_r(1'b0, 5, 5, 0, 6), 1'b1, 1'b0);
    checks++;
    if (rdy_seen !== 1'b1 || out_valid !== 1'b1 || need_forward !== 2'b00) begin
      errors++;
      $display("FAIL async_after: ready %b v %b nf %b, want ready 1 v 1 nf 00", rdy_seen, out_valid, need_forward);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] bad [5] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011};
    int k = $urandom_range(0, 5);
    int ra = $urandom_range(0, 3), rb = $urandom_range(0, 3), rd = $urandom_range(0, 3);
    int f3 = $urandom_range(0, 7);
    logic [31:0] w = $urandom;
    case (k)
      0: return enc_r(1'($urandom_range(0, 1)), rb, ra, f3, rd);
      1: begin
        if (f3 == 1 || f3 == 5)
          return enc_i(7'b0010011, {1'b0, (f3 == 5) ? 1'($urandom_range(0, 1)) : 1'b0, 5'd0, w[4:0]}, ra, f3, rd);
        return enc_i(7'b0010011, w[31:20], ra, f3, rd);
      end
      2: return enc_i(7'b0000011, w[31:20], ra, f3, rd);
      3: return {w[31:25], 5'(rb), 5'(ra), 3'(f3), w[11:7], 7'b0100011};
      4: return {w[31:25], 5'(rb), 5'(ra), 3'(f3), w[11:7], 7'b1100011};
      default: return {w[31:7], bad[$urandom_range(0, 4)]};
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] ins = 32'd0;
    logic        v, f, held = 1'b0;
    for (int n = 0; n < 400; n++) begin
      f = ($urandom_range(0, 19) == 0);
      if (held) v = 1'b1;
      else begin
        v = ($urandom_range(0, 6) != 0);
        ins = rand_instr();
      end
      cycle(ins, v, f);
      held = v && !f && !ref_rdy;
      checks++;
      if (rdy_seen !== ref_rdy) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b want %b instr %h", n, rdy_seen, ref_rdy, ins);
      end
      checks++;
      if (actual() !== ref_q) begin
        errors++;
        $display("FAIL rand_slot[%0d]: got %h want %h instr %h", n, actual(), ref_q, ins);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward_sub();
    test_load_use();
    test_stall_flush();
    test_srai_x0();
    test_branch_illegal();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
